// File: rtl/rx_pkt_sram_writer_if.sv
// RX byte stream plus SRAM master-write handshake between the packet writer and its neighbours.
// master = packet writer view; slave = RX front end / SRAM controller view.
interface rx_pkt_sram_writer_if;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic        rx_byte_ready;
  logic        rx_pkt_start;
  logic        rx_pkt_end;
  logic        rx_crc_ok;
  logic        fifo_o_full;
  logic        master_write;
  logic [15:0] master_data_to_sram;
  logic        master_hint;
  logic        Pkt_Start_flag;
  logic        Crc_Error_Rollback;

  modport master (
    input  rx_byte, rx_byte_valid, rx_pkt_start, rx_pkt_end, rx_crc_ok,
    input  fifo_o_full, master_hint,
    output rx_byte_ready, master_write, master_data_to_sram,
    output Pkt_Start_flag, Crc_Error_Rollback
  );

  modport slave (
    output rx_byte, rx_byte_valid, rx_pkt_start, rx_pkt_end, rx_crc_ok,
    output fifo_o_full, master_hint,
    input  rx_byte_ready, master_write, master_data_to_sram,
    input  Pkt_Start_flag, Crc_Error_Rollback
  );
endinterface

// File: rtl/rx_pkt_sram_writer.sv
// Packs RX bytes into 16-bit words for FIFO_O, one write per two bytes, rolling back bad packets.
// Write requested the cycle after the pair completes; RX is stalled (ready=0) while a word is pending or FIFO_O is full.
module rx_pkt_sram_writer #(
  parameter int MAX_PKT_BYTES = 255,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rx_pkt_sram_writer_if.master bus,
  output logic [CNT_W-1:0]     pkt_ok_cnt,
  output logic [CNT_W-1:0]     pkt_drop_cnt
);
  localparam int BC_W = $clog2(MAX_PKT_BYTES + 2);
  localparam logic [BC_W-1:0] MAX_B = BC_W'(MAX_PKT_BYTES);

  typedef enum logic [2:0] {
    IDLE, COLLECT, REQ, HINT_LOW, COMMIT, ROLLBACK, DRAIN
  } state_t;

  state_t          state, state_nxt;
  logic [BC_W-1:0] byte_cnt;
  logic [7:0]      hi_byte;
  logic            have_hi;
  logic [15:0]     word;
  logic            pkt_ended;
  logic            crc_bad;
  logic            drain_pend;

  logic ready_c, start_c, write_c, rb_c, abort_c, byte_acc;

  assign byte_acc = bus.rx_byte_valid && ready_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    start_c   = 1'b0;
    write_c   = 1'b0;
    rb_c      = 1'b0;
    abort_c   = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.rx_byte_valid && bus.rx_pkt_start) begin
          start_c   = 1'b1;
          state_nxt = bus.rx_pkt_end ? REQ : COLLECT;
        end
      end
      COLLECT: begin
        // A fresh start byte is left pending; IDLE accepts it after the rollback.
        if (bus.rx_byte_valid && bus.rx_pkt_start) begin
          state_nxt = ROLLBACK;
        end else begin
          ready_c = 1'b1;
          if (bus.rx_byte_valid) begin
            if (byte_cnt == MAX_B) begin
              abort_c   = 1'b1;
              state_nxt = ROLLBACK;
            end else if (have_hi || bus.rx_pkt_end) begin
              state_nxt = REQ;
            end
          end
        end
      end
      REQ: begin
        write_c = !bus.fifo_o_full && !bus.master_hint;
        if (bus.master_hint) state_nxt = HINT_LOW;
      end
      HINT_LOW: begin
        if (!bus.master_hint) begin
          if (pkt_ended) state_nxt = crc_bad ? ROLLBACK : COMMIT;
          else           state_nxt = COLLECT;
        end
      end
      COMMIT:   state_nxt = IDLE;
      ROLLBACK: begin
        rb_c      = 1'b1;
        state_nxt = drain_pend ? DRAIN : IDLE;
      end
      DRAIN: begin
        ready_c = 1'b1;
        if (bus.rx_byte_valid && bus.rx_pkt_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ready and the start pulse are combinational on IDLE, so hold them low while reset is applied.
  assign bus.rx_byte_ready       = ready_c && !rst;
  assign bus.Pkt_Start_flag      = start_c && !rst;
  assign bus.master_write        = write_c;
  assign bus.Crc_Error_Rollback  = rb_c;
  assign bus.master_data_to_sram = word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt     <= '0;
      hi_byte      <= '0;
      have_hi      <= 1'b0;
      word         <= '0;
      pkt_ended    <= 1'b0;
      crc_bad      <= 1'b0;
      drain_pend   <= 1'b0;
      pkt_ok_cnt   <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      if (byte_acc && state == IDLE && bus.rx_pkt_start) begin
        byte_cnt   <= BC_W'(1);
        pkt_ended  <= bus.rx_pkt_end;
        crc_bad    <= bus.rx_pkt_end && !bus.rx_crc_ok;
        drain_pend <= 1'b0;
        hi_byte    <= bus.rx_byte;
        have_hi    <= !bus.rx_pkt_end;
        if (bus.rx_pkt_end) word <= {bus.rx_byte, 8'h00};
      end else if (byte_acc && state == COLLECT) begin
        if (abort_c) begin
          drain_pend <= !bus.rx_pkt_end;
          have_hi    <= 1'b0;
        end else begin
          byte_cnt <= byte_cnt + BC_W'(1);
          if (bus.rx_pkt_end) begin
            pkt_ended <= 1'b1;
            crc_bad   <= !bus.rx_crc_ok;
          end
          if (have_hi) begin
            word    <= {hi_byte, bus.rx_byte};
            have_hi <= 1'b0;
          end else if (bus.rx_pkt_end) begin
            word <= {bus.rx_byte, 8'h00};
          end else begin
            hi_byte <= bus.rx_byte;
            have_hi <= 1'b1;
          end
        end
      end
      if (state == COMMIT)   pkt_ok_cnt   <= pkt_ok_cnt + CNT_W'(1);
      if (state == ROLLBACK) pkt_drop_cnt <= pkt_drop_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_rx_pkt_sram_writer.sv
// Scoreboard bench: packet-level model predicts start/write/rollback events; a monitor pops and compares them.
module tb_rx_pkt_sram_writer;
  localparam int MAX = 4;
  localparam int CW  = 16;
  localparam logic [1:0] EV_START = 2'd0;
  localparam logic [1:0] EV_WR    = 2'd1;
  localparam logic [1:0] EV_RB    = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] dat;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          full_dir = 1'b0;
  logic          full_rnd = 1'b0;
  logic [CW-1:0] ok_cnt, drop_cnt;

  rx_pkt_sram_writer_if sif();
  assign sif.fifo_o_full = full_dir | full_rnd;

  rx_pkt_sram_writer #(.MAX_PKT_BYTES(MAX), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (sif),
    .pkt_ok_cnt   (ok_cnt),
    .pkt_drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  ev_t         exp_q[$];
  logic [7:0]  pk[$];
  int          errors = 0;
  int          checks = 0;
  int          exp_ok = 0;
  int          exp_drop = 0;
  bit          ctrl_busy = 1'b0;
  bit          rnd_full_en = 1'b0;
  bit          wr_open = 1'b0;
  logic [15:0] wr_dat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic ev_t ev(input logic [1:0] k, input logic [15:0] d);
    ev_t e;
    e.kind = k;
    e.dat  = d;
    return e;
  endfunction

  task automatic pop_expect(input logic [1:0] kind, input logic [15:0] dat);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d data %h, want no event (t=%0t)", kind, dat, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.dat !== dat) begin
        errors++;
        $display("FAIL event_order: got kind %0d data %h, want kind %0d data %h (t=%0t)",
                 kind, dat, e.kind, e.dat, $time);
      end
    end
  endtask

  // Packet-level reference: words are byte pairs of what fits in MAX, rollback unless complete and CRC-good.
  task automatic model_pkt(input bit has_end, input bit crc);
    int n;
    int acc;
    n = pk.size();
    exp_q.push_back(ev(EV_START, 16'h0000));
    if (has_end && n <= MAX) begin
      for (int i = 0; i < n; i += 2)
        exp_q.push_back(ev(EV_WR, {pk[i], (i + 1 < n) ? pk[i+1] : 8'h00}));
      if (crc) exp_ok++;
      else begin
        exp_q.push_back(ev(EV_RB, 16'h0000));
        exp_drop++;
      end
    end else begin
      acc = (n > MAX) ? MAX : n;
      for (int i = 0; i + 1 < acc; i += 2)
        exp_q.push_back(ev(EV_WR, {pk[i], pk[i+1]}));
      exp_q.push_back(ev(EV_RB, 16'h0000));
      exp_drop++;
    end
  endtask

  task automatic load(input logic [63:0] v, input int n);
    pk.delete();
    for (int i = 0; i < n; i++) pk.push_back(v[8*(n-1-i) +: 8]);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit s, input bit e, input bit crc);
    int n;
    n = 0;
    sif.rx_byte       = b;
    sif.rx_pkt_start  = s;
    sif.rx_pkt_end    = e;
    sif.rx_crc_ok     = crc;
    sif.rx_byte_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!sif.rx_byte_ready && n < 400);
    check("byte_accept", 32'(sif.rx_byte_ready), 32'd1);
    @(posedge clk);
    #1;
    sif.rx_byte_valid = 1'b0;
    sif.rx_pkt_start  = 1'b0;
    sif.rx_pkt_end    = 1'b0;
    sif.rx_crc_ok     = 1'(($urandom));
  endtask

  task automatic send_pkt(input bit has_end, input bit crc, input int gmax);
    bit last;
    model_pkt(has_end, crc);
    for (int i = 0; i < pk.size(); i++) begin
      last = has_end && (i == pk.size() - 1);
      send_byte(pk[i], i == 0, last, last ? crc : 1'($urandom));
      repeat ($urandom_range(0, gmax)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // SRAM controller: acknowledges each write with a 2-cycle hint after a random delay.
  initial begin
    sif.master_hint = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && sif.master_write && !ctrl_busy) begin
        ctrl_busy = 1'b1;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk);
        #1 sif.master_hint = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 sif.master_hint = 1'b0;
        ctrl_busy = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_full_en && !ctrl_busy) full_rnd = ($urandom_range(0, 3) == 0);
      else if (!rnd_full_en)         full_rnd = 1'b0;
    end
  end

  // Monitor: every observable event is matched against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        wr_open = 1'b0;
      end else begin
        if (sif.Pkt_Start_flag) pop_expect(EV_START, 16'h0000);
        if (sif.Crc_Error_Rollback) begin
          pop_expect(EV_RB, 16'h0000);
          check("rollback_quiet", 32'({sif.master_write, sif.master_hint}), 32'd0);
        end
        if (sif.fifo_o_full) check("write_while_full", 32'(sif.master_write), 32'd0);
        if (sif.master_write && !wr_open) begin
          pop_expect(EV_WR, sif.master_data_to_sram);
          wr_open = 1'b1;
          wr_dat  = sif.master_data_to_sram;
        end else if (sif.master_write) begin
          check("write_data_stable", 32'(sif.master_data_to_sram), 32'(wr_dat));
        end
        if (sif.master_hint) begin
          check("write_drop_on_hint", 32'(sif.master_write), 32'd0);
          wr_open = 1'b0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int len;
    bit term;
    bit crc;
    sif.rx_byte       = 8'h00;
    sif.rx_byte_valid = 1'b0;
    sif.rx_pkt_start  = 1'b0;
    sif.rx_pkt_end    = 1'b0;
    sif.rx_crc_ok     = 1'b0;
    #3;
    check("rst_ready",    32'(sif.rx_byte_ready),       32'd0);
    check("rst_write",    32'(sif.master_write),        32'd0);
    check("rst_data",     32'(sif.master_data_to_sram), 32'd0);
    check("rst_start",    32'(sif.Pkt_Start_flag),      32'd0);
    check("rst_rollback", 32'(sif.Crc_Error_Rollback),  32'd0);
    check("rst_ok_cnt",   32'(ok_cnt),                  32'd0);
    check("rst_drop_cnt", 32'(drop_cnt),                32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    load(64'h11223344, 4);
    send_pkt(1'b1, 1'b1, 2);
    load(64'hAABBCC, 3);
    send_pkt(1'b1, 1'b0, 1);

    // FIFO_O full for 20 cycles with the first word pending.
    full_dir = 1'b1;
    load(64'h01020304, 4);
    model_pkt(1'b1, 1'b1);
    send_byte(pk[0], 1'b1, 1'b0, 1'b0);
    send_byte(pk[1], 1'b0, 1'b0, 1'b0);
    repeat (20) begin
      @(negedge clk);
      check("full_no_write", 32'(sif.master_write),        32'd0);
      check("full_no_ready", 32'(sif.rx_byte_ready),       32'd0);
      check("full_word",     32'(sif.master_data_to_sram), 32'h0102);
    end
    @(posedge clk);
    #1 full_dir = 1'b0;
    send_byte(pk[2], 1'b0, 1'b0, 1'b0);
    send_byte(pk[3], 1'b0, 1'b1, 1'b1);

    load(64'h21222324252627, 7);
    send_pkt(1'b1, 1'b1, 1);
    load(64'h3132, 2);
    send_pkt(1'b0, 1'b1, 0);
    load(64'h414243, 3);
    send_pkt(1'b1, 1'b1, 0);
    wait_drain();
    check("ok_cnt_directed",   32'(ok_cnt),   32'(exp_ok));
    check("drop_cnt_directed", 32'(drop_cnt), 32'(exp_drop));

    // Reset while a word is stalled in the request state.
    full_dir = 1'b1;
    load(64'h5A6B, 2);
    exp_q.push_back(ev(EV_START, 16'h0000));
    send_byte(pk[0], 1'b1, 1'b0, 1'b0);
    send_byte(pk[1], 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("stalled_before_rst", 32'(sif.master_write), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready",    32'(sif.rx_byte_ready),       32'd0);
    check("midrst_write",    32'(sif.master_write),        32'd0);
    check("midrst_data",     32'(sif.master_data_to_sram), 32'd0);
    check("midrst_start",    32'(sif.Pkt_Start_flag),      32'd0);
    check("midrst_rollback", 32'(sif.Crc_Error_Rollback),  32'd0);
    check("midrst_ok_cnt",   32'(ok_cnt),                  32'd0);
    check("midrst_drop_cnt", 32'(drop_cnt),                32'd0);
    check("midrst_queue",    32'(exp_q.size()),            32'd0);
    exp_ok   = 0;
    exp_drop = 0;
    full_dir = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    rnd_full_en = 1'b1;
    for (int p = 0; p < 60; p++) begin
      len  = $urandom_range(1, 7);
      term = ($urandom_range(0, 7) != 0);
      crc  = ($urandom_range(0, 3) != 0);
      if (!term && len > MAX) len = $urandom_range(1, MAX);
      pk.delete();
      for (int i = 0; i < len; i++) pk.push_back(8'($urandom));
      send_pkt(term, crc, 2);
      if (term && $urandom_range(0, 3) == 0) send_byte(8'($urandom), 1'b0, 1'b0, 1'b1);
    end
    load(64'hC1C2C3, 3);
    send_pkt(1'b1, 1'b1, 0);
    wait_drain();
    rnd_full_en = 1'b0;
    check("ok_cnt_final",   32'(ok_cnt),   32'(exp_ok));
    check("drop_cnt_final", 32'(drop_cnt), 32'(exp_drop));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
